bsort_ctrl: RTL and testbench
=============================

BSORT_CTRL -- requirements
Module: bsort_ctrl

Interface
REQ-001 Parameter: DESCEND, default 0; 0 = ascending sort, 1 = descending sort.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to load and sort one 8-entry set.
REQ-005 Aout  input  8  register-file read data at AIndex (combinational).
REQ-006 Bout  input  8  register-file read data at BIndex (combinational).
REQ-007 qin  output  1  shift-load enable to the register file.
REQ-008 AIndex  output  3  port-A index to the register file.
REQ-009 BIndex  output  3  port-B index to the register file.
REQ-010 w_en  output  1  write enable for both register-file ports.
REQ-011 DinA  output  8  write data for the AIndex entry.
REQ-012 DinB  output  8  write data for the BIndex entry.
REQ-013 busy  output  1  high in LOAD and SORT.
REQ-014 done  output  1  one-cycle pulse when the sort is complete.
REQ-015 swaps  output  5  count of swaps in the current or last sort (0..28).

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, SORT and DONE.
REQ-017 IDLE SHALL move to LOAD when start=1, and SHALL clear swaps, pass and j to 0 on that transition.
REQ-018 LOAD SHALL drive qin=1 for exactly 8 consecutive cycles, using a 3-bit counter, and then move to SORT.
- The external source presents one datum on the data bus per cycle.
- After the 8th cycle, the first datum resides in entry 7.
REQ-019 qin SHALL be 0 in every state other than LOAD, and w_en SHALL be 0 during LOAD.
REQ-020 In SORT, AIndex SHALL equal j and BIndex SHALL equal j+1.
- j ranges from 0 to limit, where limit = 6 - pass.
- pass ranges from 0 to 6.
REQ-021 In SORT, each cycle SHALL be one compare with a single-cycle decision.
- Swap condition: Aout > Bout (unsigned) when DESCEND=0; Aout < Bout when DESCEND=1.
- Equal values SHALL never swap.
REQ-022 On a swap cycle, the outputs SHALL be w_en=1, DinA=Bout and DinB=Aout, all combinational in the same cycle.
- The register file captures both values on the next edge.
REQ-023 On a non-swap cycle, w_en SHALL be 0.
- DinA and DinB SHALL still follow Bout and Aout, respectively.
REQ-024 Each swap cycle SHALL increment swaps by 1 and set a per-pass swapped flag.
- swaps saturates at 28.
REQ-025 At j=limit, the FSM SHALL evaluate the end of the pass.
- Move to DONE if pass=6, or if no swap occurred anywhere in the pass (current cycle included).
- Otherwise, increment pass, reset j to 0 and clear the swapped flag.
REQ-026 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
- swaps SHALL hold its value until the next start is accepted.
REQ-027 start SHALL be ignored in LOAD, SORT and DONE, with no restart and no queuing.
REQ-028 start held high SHALL begin a new sort on the first IDLE cycle.
REQ-029 Outside SORT, AIndex SHALL be 0, BIndex SHALL be 1 and w_en SHALL be 0.
REQ-030 Worst case SHALL be 8 LOAD + 28 SORT + 1 DONE cycles.
- Best case (already sorted) SHALL be 8 + 7 + 1 cycles.

Reset
REQ-031 When rst_n=0, the block SHALL immediately (asynchronously) enter IDLE.
- Reset values: qin=0, w_en=0, AIndex=0, BIndex=1, busy=0, done=0, swaps=0.
- The LOAD counter, pass, j and the swapped flag SHALL also clear to 0.
REQ-032 Reset during LOAD or SORT SHALL abandon the operation without a done pulse.
- The register-file contents are then unspecified.
- A new start after reset release SHALL run a complete load and sort.

Verification
REQ-033 Load 1,2,3,4,5,6,7,8 (ascending) -> 7 SORT cycles, w_en never 1, swaps=0, done 16 cycles after start accepted.
REQ-034 Load a strictly decreasing set (entries 0..7 = 8,7,...,1 after load) -> 28 SORT cycles, swaps=28, final entries 0..7 = 1..8, done pulse once.
REQ-035 Load all values equal to 0x55 -> no writes, swaps=0, early exit after pass 0.
REQ-036 DESCEND=1 with an ascending load -> entries end descending, swaps=28; values 0x00 and 0xFF compared unsigned.
REQ-037 Pulse start during SORT -> no effect on j, pass or swaps; exactly one done.
REQ-038 Deassert rst_n mid-SORT (pass 2) -> outputs at reset values at once, no done; next start runs to a correct completion.

Source files
------------

// File: rtl/bsort_ctrl.sv
// Bubble-sort controller for an external 8-entry, dual-port register file.
// Shift-loads eight data, then runs compare/swap passes with early exit.
module bsort_ctrl #(
  parameter bit DESCEND = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] Aout,
  input  logic [7:0] Bout,
  output logic       qin,
  output logic [2:0] AIndex,
  output logic [2:0] BIndex,
  output logic       w_en,
  output logic [7:0] DinA,
  output logic [7:0] DinB,
  output logic       busy,
  output logic       done,
  output logic [4:0] swaps
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SORT, S_DONE} state_t;

  state_t     r_state, w_next;
  logic [2:0] r_load_cnt;
  logic [2:0] r_pass;
  logic [2:0] r_j;
  logic       r_swapped;
  logic [4:0] r_swaps;
  logic [2:0] w_limit;
  logic       w_swap;

  // Unsigned compare; equal values are never out of order.
  function automatic logic out_of_order(input logic [7:0] a, input logic [7:0] b);
    if (DESCEND) return a < b;
    else         return a > b;
  endfunction

  assign w_limit = 3'd6 - r_pass;
  assign DinA    = Bout;
  assign DinB    = Aout;
  assign swaps   = r_swaps;

  always_comb begin
    w_next = r_state;
    qin    = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    AIndex = 3'd0;
    BIndex = 3'd1;
    w_en   = 1'b0;
    w_swap = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        qin  = 1'b1;
        busy = 1'b1;
        if (r_load_cnt == 3'd7) w_next = S_SORT;
      end
      S_SORT: begin
        busy   = 1'b1;
        AIndex = r_j;
        BIndex = r_j + 3'd1;
        w_swap = out_of_order(Aout, Bout);
        w_en   = w_swap;
        // The current compare counts toward the early-exit decision.
        if (r_j == w_limit) begin
          if (r_pass == 3'd6 || !(r_swapped || w_swap)) w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_load_cnt <= 3'd0;
      r_pass     <= 3'd0;
      r_j        <= 3'd0;
      r_swapped  <= 1'b0;
      r_swaps    <= 5'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_load_cnt <= 3'd0;
            r_pass     <= 3'd0;
            r_j        <= 3'd0;
            r_swapped  <= 1'b0;
            r_swaps    <= 5'd0;
          end
        end
        S_LOAD: r_load_cnt <= r_load_cnt + 3'd1;
        S_SORT: begin
          if (w_swap && r_swaps != 5'd28) r_swaps <= r_swaps + 5'd1;
          if (r_j == w_limit) begin
            if (w_next == S_SORT) begin
              r_pass    <= r_pass + 3'd1;
              r_j       <= 3'd0;
              r_swapped <= 1'b0;
            end
          end else begin
            r_j       <= r_j + 3'd1;
            r_swapped <= r_swapped | w_swap;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bsort_ctrl.sv
// Directed bench: two controllers (ascending, descending) each drive a
// behavioural 8-entry register file fed from a shared load sequence.
module tb_bsort_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tgt [8];
  logic [7:0] din;
  logic [2:0] load_idx;
  logic [7:0] mem0 [8];
  logic [7:0] mem1 [8];

  logic       qin0, w_en0, busy0, done0, qin1, w_en1, busy1, done1;
  logic [2:0] AIndex0, BIndex0, AIndex1, BIndex1;
  logic [7:0] Aout0, Bout0, DinA0, DinB0, Aout1, Bout1, DinA1, DinB1;
  logic [4:0] swaps0, swaps1;

  bsort_ctrl #(.DESCEND(1'b0)) u_asc (
    .clk(clk), .rst_n(rst_n), .start(start), .Aout(Aout0), .Bout(Bout0),
    .qin(qin0), .AIndex(AIndex0), .BIndex(BIndex0), .w_en(w_en0),
    .DinA(DinA0), .DinB(DinB0), .busy(busy0), .done(done0), .swaps(swaps0)
  );

  bsort_ctrl #(.DESCEND(1'b1)) u_desc (
    .clk(clk), .rst_n(rst_n), .start(start), .Aout(Aout1), .Bout(Bout1),
    .qin(qin1), .AIndex(AIndex1), .BIndex(BIndex1), .w_en(w_en1),
    .DinA(DinA1), .DinB(DinB1), .busy(busy1), .done(done1), .swaps(swaps1)
  );

  // First datum presented lands in entry 7, so feed the target back to front.
  assign din   = tgt[3'd7 - load_idx];
  assign Aout0 = mem0[AIndex0];
  assign Bout0 = mem0[BIndex0];
  assign Aout1 = mem1[AIndex1];
  assign Bout1 = mem1[BIndex1];

  always @(posedge clk) load_idx <= qin0 ? load_idx + 3'd1 : 3'd0;

  always @(posedge clk) begin
    if (qin0) begin
      for (int i = 7; i > 0; i--) mem0[i] <= mem0[i-1];
      mem0[0] <= din;
    end else if (w_en0) begin
      mem0[AIndex0] <= DinA0;
      mem0[BIndex0] <= DinB0;
    end
  end

  always @(posedge clk) begin
    if (qin1) begin
      for (int i = 7; i > 0; i--) mem1[i] <= mem1[i-1];
      mem1[0] <= din;
    end else if (w_en1) begin
      mem1[AIndex1] <= DinA1;
      mem1[BIndex1] <= DinB1;
    end
  end

  int sort0 = 0, sort1 = 0, wen0 = 0, wen1 = 0, dn0 = 0, dn1 = 0;
  always @(negedge clk) begin
    if (busy0 && !qin0) sort0 = sort0 + 1;
    if (busy1 && !qin1) sort1 = sort1 + 1;
    if (w_en0) wen0 = wen0 + 1;
    if (w_en1) wen1 = wen1 + 1;
    if (done0) dn0 = dn0 + 1;
    if (done1) dn1 = dn1 + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack0();
    return {mem0[0], mem0[1], mem0[2], mem0[3], mem0[4], mem0[5], mem0[6], mem0[7]};
  endfunction
  function automatic logic [63:0] pack1();
    return {mem1[0], mem1[1], mem1[2], mem1[3], mem1[4], mem1[5], mem1[6], mem1[7]};
  endfunction

  task automatic set_tgt(input logic [63:0] v);
    for (int i = 0; i < 8; i++) tgt[i] = v[63 - 8*i -: 8];
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " qin"},    {63'd0, qin0},   64'd0);
    chk({tag, " w_en"},   {63'd0, w_en0},  64'd0);
    chk({tag, " AIndex"}, {61'd0, AIndex0}, 64'd0);
    chk({tag, " BIndex"}, {61'd0, BIndex0}, 64'd1);
    chk({tag, " busy"},   {63'd0, busy0},  64'd0);
    chk({tag, " done"},   {63'd0, done0},  64'd0);
    chk({tag, " swaps"},  {59'd0, swaps0}, 64'd0);
    chk({tag, " swaps1"}, {59'd0, swaps1}, 64'd0);
    chk({tag, " busy1"},  {63'd0, busy1},  64'd0);
  endtask

  // Runs one sort on both controllers; latency counts the accept cycle as 0.
  task automatic run_case(input string tag, input logic [63:0] load, input int pulse_at,
                          input logic [63:0] fin0, input int sw0, input int sc0,
                          input logic [63:0] fin1, input int sw1, input int sc1);
    int cyc, lat0, lat1, b_s0, b_s1, b_w0, b_w1, b_d0, b_d1;
    set_tgt(load);
    b_s0 = sort0; b_s1 = sort1; b_w0 = wen0; b_w1 = wen1; b_d0 = dn0; b_d1 = dn1;
    lat0 = 0; lat1 = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    while ((lat0 == 0 || lat1 == 0) && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (done0 && lat0 == 0) lat0 = cyc;
      if (done1 && lat1 == 0) lat1 = cyc;
      start = (cyc == pulse_at);
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, " asc swaps"},   64'(swaps0), 64'(sw0));
    chk({tag, " asc sortcyc"}, 64'(sort0 - b_s0), 64'(sc0));
    chk({tag, " asc writes"},  64'(wen0 - b_w0), 64'(sw0));
    chk({tag, " asc latency"}, 64'(lat0), 64'(sc0 + 9));
    chk({tag, " asc dones"},   64'(dn0 - b_d0), 64'd1);
    chk({tag, " asc data"},    pack0(), fin0);
    chk({tag, " desc swaps"},  64'(swaps1), 64'(sw1));
    chk({tag, " desc sortcyc"},64'(sort1 - b_s1), 64'(sc1));
    chk({tag, " desc writes"}, 64'(wen1 - b_w1), 64'(sw1));
    chk({tag, " desc latency"},64'(lat1), 64'(sc1 + 9));
    chk({tag, " desc dones"},  64'(dn1 - b_d1), 64'd1);
    chk({tag, " desc data"},   pack1(), fin1);
  endtask

  localparam logic [63:0] UP   = 64'h01020304_05060708;
  localparam logic [63:0] DOWN = 64'h08070605_04030201;
  localparam logic [63:0] SAME = 64'h55555555_55555555;
  localparam logic [63:0] EDGE_UP = 64'h00102030_405060FF;
  localparam logic [63:0] EDGE_DN = 64'hFF605040_30201000;

  initial begin
    int b_d0;
    #12;
    chk_reset_outs("reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_case("sorted",  UP,      -1, UP,      0,  7,  DOWN,    28, 28);
    run_case("reverse", DOWN,    -1, UP,      28, 28, DOWN,    0,  7);
    run_case("equal",   SAME,    -1, SAME,    0,  7,  SAME,    0,  7);
    run_case("extreme", EDGE_UP, -1, EDGE_UP, 0,  7,  EDGE_DN, 28, 28);
    run_case("midstart", DOWN,   12, UP,      28, 28, DOWN,    0,  7);

    // Abort mid-sort during pass 2 of the ascending controller.
    set_tgt(DOWN);
    b_d0 = dn0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (23) @(posedge clk);
    #2;
    chk("abort precond busy", {63'd0, busy0 & ~qin0}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("abort");
    repeat (3) @(posedge clk);
    #1;
    chk("abort no done", 64'(dn0 - b_d0), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_case("rerun", DOWN, -1, UP, 28, 28, DOWN, 0, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
